fetch_buffer: RTL and testbench

- Sits on the consumer side of the program counter, between the PC/instruction-memory fetch port and the decode stage.
- Each cycle the PC is not stalled, it captures the issued PC and pairs it with the instruction word that instruction memory returns one cycle later.
- Queues each {pc, instr} pair in a small FIFO and presents it to decode with a valid/ready handshake.
- Drives stall back to the program counter by credit and discards wrong-path fetches on a redirect.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_buffer_if.sv | 20 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/fetch_buffer.sv | 85 ++++++++
 tb/tb_fetch_buffer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // Canonical NOP (addi x0, x0, 0), used downstream for bubble insertion.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction paired with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Decode-side handshake of the fetch buffer: head entry plus valid/ready.
interface fetch_buffer_if #(
    parameter int WIDTH = 32
);
    logic             valid_o;
    logic             ready_i;
    logic [31:0]      instr_o;
    logic [WIDTH-1:0] pc_o;
    logic [WIDTH-1:0] pc_plus4_o;

    modport master (
        output valid_o, instr_o, pc_o, pc_plus4_o,
        input  ready_i
    );

    modport slave (
        input  valid_o, instr_o, pc_o, pc_plus4_o,
        output ready_i
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; DEPTH must be a power of two.
module sync_fifo
    import riscv_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  entry_t           wdata,
    output entry_t           rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];

    // Next-state pointers and occupancy; clear overrides any push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head outputs never carry X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: pairs each issued PC with the instruction returned one cycle
// later, queues the pairs for decode and back-pressures the PC by credit.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_i,
    input  logic             flush,
    input  logic [31:0]      imem_rdata,
    output logic             stall_o,
    fetch_buffer_if.master   dec
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic             inflight_v_q, inflight_v_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             issue;
    logic             push;
    logic             pop;
    logic             valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic [CNT_W:0]   credit_used;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Credit check uses registered state only, so stall never depends on
    // ready_i or flush in the same cycle.
    always_comb begin
        credit_used   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_v_q};
        stall_o       = (credit_used >= CREDITS);
        issue         = !stall_o && !flush;
        inflight_v_d  = issue;
        inflight_pc_d = issue ? pc_i : inflight_pc_q;
        push          = inflight_v_q && !flush;
        valid         = !empty && !flush;
        pop           = valid && dec.ready_i;
        wr_entry.pc    = inflight_pc_q;
        wr_entry.instr = imem_rdata;
    end

    // In-flight slot: remembers the PC whose instruction returns next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .entry_t (fetch_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign dec.valid_o    = valid;
    assign dec.pc_o       = head.pc;
    assign dec.instr_o    = head.instr;
    // Held at zero while empty so every output reads 0 out of reset.
    assign dec.pc_plus4_o = empty ? '0 : head.pc + WIDTH'(INSTR_BYTES);

    // Credit accounting must make an overflowing push impossible.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed PC streams, monitor on decode handshake.
module tb_fetch_buffer;
    import riscv_pkg::*;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        flush      = 1'b0;
    logic [31:0] pc_i       = '0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] target     = '0;
    logic        stall_o;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [31:0] expq[$];
    logic [31:0] mon_exp;

    fetch_buffer_if #(.WIDTH(32)) dec ();

    fetch_buffer #(.WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .flush      (flush),
        .imem_rdata (imem_rdata),
        .stall_o    (stall_o),
        .dec        (dec)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return p ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fill_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) expq.push_back(start + 32'(4 * i));
    endtask

    // One clock: PC model and instruction memory advance at the edge.
    task automatic tick();
        logic [31:0] nxt;
        @(negedge clk);
        if (!rst)         nxt = '0;
        else if (flush)   nxt = target;
        else if (stall_o) nxt = pc_i;
        else              nxt = pc_i + 32'd4;
        @(posedge clk);
        #1;
        imem_rdata = instr_of(pc_i);
        pc_i       = nxt;
    endtask

    task automatic do_reset();
        dec.ready_i = 1'b0;
        flush       = 1'b0;
        rst         = 1'b0;
        tick();
        tick();
        expq.delete();
        pops = 0;
    endtask

    // Monitor: every accepted head entry is compared with the scoreboard.
    always @(negedge clk) begin
        if (rst && dec.valid_o && dec.ready_i) begin
            pops++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected actual pc=%h required=none", dec.pc_o);
            end else begin
                mon_exp = expq.pop_front();
                check("pop_pc", dec.pc_o, mon_exp);
                check("pop_instr", dec.instr_o, instr_of(mon_exp));
                check("pop_pc_plus4", dec.pc_plus4_o, mon_exp + 32'd4);
            end
        end
    end

    initial begin
        dec.ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_valid", 32'(dec.valid_o), 32'd0);
        check("rst_pc", dec.pc_o, 32'd0);
        check("rst_instr", dec.instr_o, 32'd0);
        check("rst_pc_plus4", dec.pc_plus4_o, 32'd0);

        // Streaming with decode always ready.
        fill_exp(32'h0, 16);
        dec.ready_i = 1'b1;
        rst = 1'b1;
        check("t1_valid_c0", 32'(dec.valid_o), 32'd0);
        tick();
        check("t1_valid_c1", 32'(dec.valid_o), 32'd0);
        tick();
        check("t1_valid_c2", 32'(dec.valid_o), 32'd1);
        check("t1_pc_c2", dec.pc_o, 32'h0);
        for (int c = 0; c < 7; c++) begin
            tick();
            check("t1_stall", 32'(stall_o), 32'd0);
        end
        check("t1_pops", 32'(pops), 32'd7);

        // Fill with decode stalled, then release one entry.
        do_reset();
        fill_exp(32'h0, 16);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("t2_stall_low", 32'(stall_o), 32'd0);
            tick();
        end
        check("t2_stall_high", 32'(stall_o), 32'd1);
        tick();
        tick();
        check("t2_stall_hold", 32'(stall_o), 32'd1);
        check("t2_pc_held", pc_i, 32'h10);
        check("t2_valid", 32'(dec.valid_o), 32'd1);
        check("t2_head", dec.pc_o, 32'h0);
        dec.ready_i = 1'b1;
        tick();
        dec.ready_i = 1'b0;
        check("t2_one_pop", 32'(pops), 32'd1);
        check("t2_stall_fall", 32'(stall_o), 32'd0);
        tick();
        check("t2_stall_refill", 32'(stall_o), 32'd1);
        tick();
        check("t2_stall_full", 32'(stall_o), 32'd1);
        dec.ready_i = 1'b1;
        repeat (10) tick();
        check("t2_pops", 32'(pops), 32'd11);

        // Flush with 3 queued, one in flight, stall high and decode ready.
        do_reset();
        rst = 1'b1;
        repeat (4) tick();
        check("t3_stall_pre", 32'(stall_o), 32'd1);
        check("t3_valid_pre", 32'(dec.valid_o), 32'd1);
        expq.delete();
        fill_exp(32'h100, 16);
        target      = 32'h100;
        flush       = 1'b1;
        dec.ready_i = 1'b1;
        #1;
        check("t3_valid_flush", 32'(dec.valid_o), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("t3_valid_after", 32'(dec.valid_o), 32'd0);
        check("t3_stall_after", 32'(stall_o), 32'd0);
        check("t3_target_pc", pc_i, 32'h100);
        check("t3_no_pop", 32'(pops), 32'd0);
        tick();
        check("t3_valid_c6", 32'(dec.valid_o), 32'd0);
        tick();
        check("t3_valid_c7", 32'(dec.valid_o), 32'd1);
        check("t3_head_target", dec.pc_o, 32'h100);
        repeat (5) tick();
        check("t3_pops", 32'(pops), 32'd5);

        // Asynchronous reset mid-stream with entries queued.
        dec.ready_i = 1'b0;
        tick();
        tick();
        check("t4_valid_pre", 32'(dec.valid_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t4_stall", 32'(stall_o), 32'd0);
        check("t4_valid", 32'(dec.valid_o), 32'd0);
        check("t4_pc", dec.pc_o, 32'd0);
        check("t4_instr", dec.instr_o, 32'd0);
        check("t4_pc_plus4", dec.pc_plus4_o, 32'd0);
        expq.delete();
        pops = 0;
        dec.ready_i = 1'b1;
        tick();
        rst = 1'b1;
        fill_exp(32'h0, 8);
        tick();
        tick();
        check("t4_restart_valid", 32'(dec.valid_o), 32'd1);
        check("t4_restart_pc", dec.pc_o, 32'h0);
        repeat (4) tick();
        check("t4_pops", 32'(pops), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
